// File: rtl/img_sram_arbiter.sv
// Round-robin, ownership-locked arbiter sharing the image SRAM port among NREQ requesters.
// Optional forced handoff after MAX_BURST accesses: define IMG_ARB_BURST_LIMIT_EN.
module img_sram_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned ROW_W     = 8,
  parameter int unsigned COL_W     = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ROW_W-1:0]    req_row,
  input  logic [NREQ*COL_W-1:0]    req_col,
  input  logic [NREQ*DATA_W-1:0]   req_din,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     sram_sense_en,
  output logic                     sram_write_en,
  output logic [ROW_W-1:0]         sram_row,
  output logic [COL_W-1:0]         sram_col,
  output logic [DATA_W-1:0]        sram_din,
  input  logic [DATA_W-1:0]        sram_dout
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            any_req;
  logic            access;

`ifdef IMG_ARB_BURST_LIMIT_EN
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BW-1:0] burst_cnt;
  logic          others;
  assign others = |(req & ~gnt);
`endif

  assign any_req = |req;
  assign access  = |(gnt & req);
  assign rdata   = sram_dout;

  // While OWNED, rr_ptr is the owner, so one search covers both idle pick and handoff.
  always_comb begin
    win = rr_ptr;
    for (int unsigned d = NREQ; d >= 1; d--) begin
      if (req[(32'(rr_ptr) + d) % NREQ]) win = PW'((32'(rr_ptr) + d) % NREQ);
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_comb begin
    sram_sense_en = 1'b0;
    sram_write_en = 1'b0;
    sram_row      = '0;
    sram_col      = '0;
    sram_din      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i] && req[i]) begin
        sram_sense_en = 1'b1;
        sram_write_en = req_we[i];
        sram_row      = req_row[i*ROW_W +: ROW_W];
        sram_col      = req_col[i*COL_W +: COL_W];
        sram_din      = req_din[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      gnt    <= '0;
      rvalid <= '0;
      rr_ptr <= PW'(NREQ - 1);
`ifdef IMG_ARB_BURST_LIMIT_EN
      burst_cnt <= '0;
`endif
    end else begin
      // Tagged with the issuing requester so a handoff at the same edge cannot misroute it.
      rvalid <= gnt & req & ~req_we;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt    <= win_oh;
            rr_ptr <= win;
            state  <= OWNED;
          end
`ifdef IMG_ARB_BURST_LIMIT_EN
          burst_cnt <= '0;
`endif
        end
        OWNED: begin
          if (!access) begin
            if (any_req) begin
              gnt    <= win_oh;
              rr_ptr <= win;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
`ifdef IMG_ARB_BURST_LIMIT_EN
            burst_cnt <= '0;
          end else if (burst_cnt == BW'(MAX_BURST - 1)) begin
            burst_cnt <= '0;
            if (others) begin
              gnt    <= win_oh;
              rr_ptr <= win;
            end
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
`endif
          end
        end
      endcase
    end
  end

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));

endmodule

// File: tb/tb_img_sram_arbiter.sv
// Bench for img_sram_arbiter: directed vector table, corner sequences, and random traffic
// checked against an owner/queue-level reference model of the arbitration rules.
module tb_img_sram_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  req, req_we;
  logic [23:0] req_row, req_col, req_din;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, sram_row, sram_col, sram_din, sram_dout;
  logic        sram_sense_en, sram_write_en;

  img_sram_arbiter #(.NREQ(3), .ROW_W(8), .COL_W(8), .DATA_W(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_row(req_row),
    .req_col(req_col), .req_din(req_din), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_sense_en(sram_sense_en), .sram_write_en(sram_write_en), .sram_row(sram_row),
    .sram_col(sram_col), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM environment: registered read data
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (sram_sense_en) begin
      if (sram_write_en) mem[{sram_row, sram_col}] <= sram_din;
      else               sram_dout <= mem[{sram_row, sram_col}];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic init_mems();
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] ad;
      ad = 16'(a);
      mem[a]     = ad[7:0] ^ ad[15:8];
      ref_mem[a] = ad[7:0] ^ ad[15:8];
    end
    mem[16'h0507]     = 8'h5A;
    ref_mem[16'h0507] = 8'h5A;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req = '0; req_we = '0; req_row = '0; req_col = '0; req_din = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- reference model ----------------
  int         m_owner, m_last, m_pend, m_cnt;
  logic [15:0] m_paddr;

  function automatic int next_after(input int p, input logic [2:0] r);
    for (int d = 1; d <= 3; d++) if (r[(p + d) % 3]) return (p + d) % 3;
    return -1;
  endfunction

  task automatic model_init();
    m_owner = -1; m_last = 2; m_pend = -1; m_cnt = 0; m_paddr = '0;
  endtask

  task automatic model_step();
    int   o;
    logic acc;
    o   = m_owner;
    acc = (o >= 0) && req[o];
    if (acc && !req_we[o]) begin
      m_pend  = o;
      m_paddr = {req_row[o*8 +: 8], req_col[o*8 +: 8]};
    end else m_pend = -1;
    if (acc && req_we[o]) ref_mem[{req_row[o*8 +: 8], req_col[o*8 +: 8]}] = req_din[o*8 +: 8];
    if (o < 0) begin
      if (req != 0) begin m_owner = next_after(m_last, req); m_last = m_owner; m_cnt = 0; end
    end else if (!acc) begin
      m_cnt = 0;
      if (req != 0) begin m_owner = next_after(o, req); m_last = m_owner; end
      else m_owner = -1;
    end
`ifdef IMG_ARB_BURST_LIMIT_EN
    else if (m_cnt == MB - 1) begin
      m_cnt = 0;
      if ((req & ~(3'b001 << o)) != 0) begin m_owner = next_after(o, req); m_last = m_owner; end
    end else m_cnt++;
`endif
  endtask

  task automatic model_check();
    logic [2:0] eg, ev;
    logic       acc;
    eg = '0; ev = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_pend >= 0)  ev[m_pend]  = 1'b1;
    acc = (m_owner >= 0) && req[m_owner];
    chk("rnd_gnt", gnt, eg);
    chk("rnd_rvalid", rvalid, ev);
    chk("rnd_sense", sram_sense_en, acc);
    chk("rnd_wen", sram_write_en, acc && req_we[m_owner]);
    chk("rnd_row", sram_row, acc ? req_row[m_owner*8 +: 8] : 8'h00);
    chk("rnd_col", sram_col, acc ? req_col[m_owner*8 +: 8] : 8'h00);
    chk("rnd_din", sram_din, acc ? req_din[m_owner*8 +: 8] : 8'h00);
    if (m_pend >= 0) chk("rnd_rdata", rdata, ref_mem[m_paddr]);
    chk("rnd_onehot", $onehot0(gnt), 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] req, we;
    logic [7:0] row, col, din;
    logic [2:0] gnt, rvalid;
    logic [7:0] rdata;
  } vec_t;

  vec_t vt [17];

  initial begin
    int         nev;
    int         ev [6];
    int         acnt [3];
    logic [2:0] drop, prev_g;

    vt[0]  = '{3'b001, 3'b001, 8'd3, 8'd0, 8'hA0, 3'b000, 3'b000, 8'h00};
    vt[1]  = '{3'b001, 3'b001, 8'd3, 8'd0, 8'hA0, 3'b001, 3'b000, 8'h00};
    vt[2]  = '{3'b001, 3'b001, 8'd3, 8'd1, 8'hA1, 3'b001, 3'b000, 8'h00};
    vt[3]  = '{3'b001, 3'b001, 8'd3, 8'd2, 8'hA2, 3'b001, 3'b000, 8'h00};
    vt[4]  = '{3'b001, 3'b001, 8'd3, 8'd3, 8'hA3, 3'b001, 3'b000, 8'h00};
    vt[5]  = '{3'b000, 3'b000, 8'd0, 8'd0, 8'h00, 3'b001, 3'b000, 8'h00};
    vt[6]  = '{3'b010, 3'b000, 8'd3, 8'd1, 8'h00, 3'b000, 3'b000, 8'h00};
    vt[7]  = '{3'b010, 3'b000, 8'd3, 8'd1, 8'h00, 3'b010, 3'b000, 8'h00};
    vt[8]  = '{3'b011, 3'b000, 8'd3, 8'd2, 8'h00, 3'b010, 3'b010, 8'hA1};
    vt[9]  = '{3'b001, 3'b001, 8'd3, 8'd0, 8'h55, 3'b010, 3'b010, 8'hA2};
    vt[10] = '{3'b001, 3'b001, 8'd3, 8'd0, 8'h55, 3'b001, 3'b000, 8'h00};
    vt[11] = '{3'b000, 3'b000, 8'd0, 8'd0, 8'h00, 3'b001, 3'b000, 8'h00};
    vt[12] = '{3'b000, 3'b000, 8'd0, 8'd0, 8'h00, 3'b000, 3'b000, 8'h00};
    vt[13] = '{3'b100, 3'b000, 8'd5, 8'd7, 8'h00, 3'b000, 3'b000, 8'h00};
    vt[14] = '{3'b100, 3'b000, 8'd5, 8'd7, 8'h00, 3'b100, 3'b000, 8'h00};
    vt[15] = '{3'b000, 3'b000, 8'd0, 8'd0, 8'h00, 3'b100, 3'b100, 8'h5A};
    vt[16] = '{3'b000, 3'b000, 8'd0, 8'd0, 8'h00, 3'b000, 3'b000, 8'h00};

    init_mems();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic acc;
      req = vt[i].req; req_we = vt[i].we;
      req_row = {3{vt[i].row}}; req_col = {3{vt[i].col}}; req_din = {3{vt[i].din}};
      #2;
      acc = |(vt[i].gnt & vt[i].req);
      chk("vec_gnt", gnt, vt[i].gnt);
      chk("vec_rvalid", rvalid, vt[i].rvalid);
      if (vt[i].rvalid != 0) chk("vec_rdata", rdata, vt[i].rdata);
      chk("vec_sense", sram_sense_en, acc);
      chk("vec_wen", sram_write_en, acc && |(vt[i].gnt & vt[i].we));
      chk("vec_row", sram_row, acc ? vt[i].row : 8'h00);
      chk("vec_col", sram_col, acc ? vt[i].col : 8'h00);
      chk("vec_din", sram_din, acc ? vt[i].din : 8'h00);
      @(negedge clk);
    end

    // Round-robin: everyone requests, each drops for one cycle after two accesses
    do_reset();
    nev = 0; drop = '0; prev_g = '0;
    acnt = '{0, 0, 0};
    req_we = 3'b111;
    for (int c = 0; c < 40 && nev < 6; c++) begin
      req  = ~drop;
      drop = '0;
      #2;
      chk("rr_onehot", $onehot0(gnt), 1'b1);
      if (gnt != 0 && gnt != prev_g) begin
        for (int k = 0; k < 3; k++) if (gnt[k]) ev[nev] = k;
        nev++;
      end
      prev_g = gnt;
      for (int k = 0; k < 3; k++) begin
        if (gnt[k] && req[k]) begin
          acnt[k]++;
          if (acnt[k] == 2) begin drop[k] = 1'b1; acnt[k] = 0; end
        end
      end
      @(negedge clk);
    end
    chk("rr_events", nev, 6);
    for (int k = 0; k < 6; k++) if (k < nev) chk("rr_order", ev[k], k % 3);

    // Async reset during an owned read stream
    do_reset();
    req = 3'b100; req_we = 3'b000;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_pre_rvalid", rvalid, 3'b100);
    chk("rst_pre_sense", sram_sense_en, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_wen", sram_write_en, 1'b0);
    chk("rst_sense", sram_sense_en, 1'b0);
    @(negedge clk);
    rstn = 1'b1; req = 3'b111;
    #2;
    chk("rst_idle", gnt, 3'b000);
    @(negedge clk);
    #2;
    chk("rst_first", gnt, 3'b001);
    @(negedge clk);

`ifdef IMG_ARB_BURST_LIMIT_EN
    do_reset();
    req = 3'b011; req_we = 3'b011;
    for (int c = 0; c < 14; c++) begin
      #2;
      chk("burst_gnt", gnt, (c == 0) ? 3'b000 : ((((c - 1) / MB) % 2 == 0) ? 3'b001 : 3'b010));
      @(negedge clk);
    end
    req = 3'b001;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #2;
      chk("burst_keep", gnt, 3'b001);
      @(negedge clk);
    end
`endif

    // Random traffic against the reference model
    do_reset();
    init_mems();
    model_init();
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(7) == 0) req[k] = ~req[k];
      req_we = 3'($urandom);
      for (int k = 0; k < 3; k++) begin
        req_row[k*8 +: 8] = 8'($urandom_range(3));
        req_col[k*8 +: 8] = 8'($urandom_range(3));
        req_din[k*8 +: 8] = 8'($urandom);
      end
      #2;
      model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
